// File: rtl/exhaustive_sweep_checker_if.sv
// Bundle between the sweep checker and the block it exercises: stimulus out, response in,
// plus the checker's status and result fields.
interface exhaustive_sweep_checker_if #(
    parameter int unsigned N = 3
);
    logic         start;
    logic         y_in;
    logic [N-1:0] vec_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_cnt;
    logic         first_err_valid;
    logic [N-1:0] first_err_vec;

    modport master (
        input  start, y_in,
        output vec_out, busy, done, pass, err_cnt, first_err_valid, first_err_vec
    );

    modport slave (
        output start, y_in,
        input  vec_out, busy, done, pass, err_cnt, first_err_valid, first_err_vec
    );
endinterface

// File: rtl/exhaustive_sweep_checker.sv
// Walks every N-bit input vector, holds each for HOLD cycles, and checks the sampled response
// against the TRUTH table, counting mismatches and capturing the first failing vector.
module exhaustive_sweep_checker #(
    parameter int unsigned         N     = 3,
    parameter int unsigned         HOLD  = 10,
    parameter logic [(1<<N)-1:0]   TRUTH = 8'hE8
) (
    input  logic                          clk,
    input  logic                          rst,
    exhaustive_sweep_checker_if.master    bus
);
    localparam int unsigned HW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HoldLast = HW'(HOLD - 1);
    localparam logic [N-1:0]  VecLast  = {N{1'b1}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [HW-1:0] hold_q;
    logic [N-1:0]  vec_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [N:0]    err_q;
    logic          fev_q;
    logic [N-1:0]  fvec_q;
    logic          mismatch;

    assign mismatch = (bus.y_in != TRUTH[vec_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q <= StRun;
                        hold_q  <= '0;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fev_q   <= 1'b0;
                        fvec_q  <= '0;
                    end
                end
                StRun: begin
                    if (hold_q == HoldLast) begin
                        if (mismatch) begin
                            err_q <= err_q + 1'b1;
                            if (!fev_q) begin
                                fev_q  <= 1'b1;
                                fvec_q <= vec_q;
                            end
                        end
                        // Terminal vector found by compare so vec_out parks at all-ones.
                        if (vec_q == VecLast) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0) && !mismatch;
                        end else begin
                            vec_q  <= vec_q + 1'b1;
                            hold_q <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.vec_out         = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_cnt         = err_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_vec   = fvec_q;
endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Bench for exhaustive_sweep_checker: an N=3/HOLD=2 majority instance and an N=1/HOLD=1 instance.
module tb_exhaustive_sweep_checker;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   mode3   = 0;
    int   mode1   = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    exhaustive_sweep_checker_if #(.N(3)) ifc3 ();
    exhaustive_sweep_checker_if #(.N(1)) ifc1 ();

    exhaustive_sweep_checker #(.N(3), .HOLD(2), .TRUTH(8'hE8)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifc3.master)
    );

    exhaustive_sweep_checker #(.N(1), .HOLD(1), .TRUTH(2'b10)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.master)
    );

    // Response models: 0 correct majority, 1 wrong only at 5, 2 tied low, 3 inverted.
    logic [2:0] v3;
    logic       maj;
    assign v3  = ifc3.vec_out;
    assign maj = (v3[0] & v3[1]) | (v3[0] & v3[2]) | (v3[1] & v3[2]);
    assign ifc3.y_in = (mode3 == 0) ? maj :
                       (mode3 == 1) ? (maj ^ (v3 == 3'd5)) :
                       (mode3 == 2) ? 1'b0 : ~maj;
    assign ifc1.y_in = (mode1 == 0) ? ifc1.vec_out[0] : ~ifc1.vec_out[0];

    task automatic run_sweep3(input int mode, input int exp_err, input int exp_fvec,
                              input bit pulse5, input string name);
        mode3 = mode;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(k);
            exp_q.push_back(k);
        end
        @(negedge clk);
        ifc3.start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            int ev;
            @(negedge clk);
            if (c == 0) ifc3.start = 1'b0;
            if (pulse5 && c == 4) ifc3.start = 1'b1;
            if (pulse5 && c == 5) ifc3.start = 1'b0;
            ev = exp_q.pop_front();
            n_total++;
            if (ifc3.vec_out !== 3'(ev) || ifc3.busy !== 1'b1 || ifc3.done !== 1'b0) begin
                $display("FAIL %s cycle%0d vec/busy/done got %0d/%b/%b want %0d/1/0",
                         name, c, ifc3.vec_out, ifc3.busy, ifc3.done, ev);
            end else n_pass++;
            if (c == 0) begin
                n_total++;
                if (ifc3.err_cnt !== 4'd0 || ifc3.first_err_valid !== 1'b0 ||
                    ifc3.first_err_vec !== 3'd0 || ifc3.pass !== 1'b0) begin
                    $display("FAIL %s cleared err/fev/fvec/pass got %0d/%b/%0d/%b want 0/0/0/0",
                             name, ifc3.err_cnt, ifc3.first_err_valid, ifc3.first_err_vec,
                             ifc3.pass);
                end else n_pass++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_total++;
        if (ifc3.done !== 1'b1 || ifc3.busy !== 1'b0 || ifc3.vec_out !== 3'd7) begin
            $display("FAIL %s end done/busy/vec got %b/%b/%0d want 1/0/7",
                     name, ifc3.done, ifc3.busy, ifc3.vec_out);
        end else n_pass++;
        n_total++;
        if (ifc3.err_cnt !== 4'(exp_err) || ifc3.pass !== (exp_err == 0) ||
            ifc3.first_err_valid !== (exp_err != 0) || ifc3.first_err_vec !== 3'(exp_fvec)) begin
            $display("FAIL %s results err/pass/fev/fvec got %0d/%b/%b/%0d want %0d/%b/%b/%0d",
                     name, ifc3.err_cnt, ifc3.pass, ifc3.first_err_valid, ifc3.first_err_vec,
                     exp_err, exp_err == 0, exp_err != 0, exp_fvec);
        end else n_pass++;
    endtask

    task automatic run_sweep1(input int mode, input int exp_err, input string name);
        mode1 = mode;
        exp_q.push_back(0);
        exp_q.push_back(1);
        @(negedge clk);
        ifc1.start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            int ev;
            @(negedge clk);
            if (c == 0) ifc1.start = 1'b0;
            ev = exp_q.pop_front();
            n_total++;
            if (ifc1.vec_out !== 1'(ev) || ifc1.busy !== 1'b1) begin
                $display("FAIL %s cycle%0d vec/busy got %0d/%b want %0d/1",
                         name, c, ifc1.vec_out, ifc1.busy, ev);
            end else n_pass++;
            @(posedge clk);
        end
        @(negedge clk);
        n_total++;
        if (ifc1.done !== 1'b1 || ifc1.busy !== 1'b0 || ifc1.err_cnt !== 2'(exp_err) ||
            ifc1.pass !== (exp_err == 0) || ifc1.first_err_valid !== (exp_err != 0) ||
            ifc1.first_err_vec !== 1'b0) begin
            $display("FAIL %s done/busy/err/pass/fev/fvec got %b/%b/%0d/%b/%b/%0d want 1/0/%0d/%b/%b/0",
                     name, ifc1.done, ifc1.busy, ifc1.err_cnt, ifc1.pass, ifc1.first_err_valid,
                     ifc1.first_err_vec, exp_err, exp_err == 0, exp_err != 0);
        end else n_pass++;
    endtask

    task automatic check_idle(input string name);
        n_total++;
        if (ifc3.vec_out !== 3'd0 || ifc3.busy !== 1'b0 || ifc3.done !== 1'b0 ||
            ifc3.pass !== 1'b0 || ifc3.err_cnt !== 4'd0 || ifc3.first_err_valid !== 1'b0 ||
            ifc3.first_err_vec !== 3'd0) begin
            $display("FAIL %s vec/busy/done/pass/err/fev/fvec got %0d/%b/%b/%b/%0d/%b/%0d want all 0",
                     name, ifc3.vec_out, ifc3.busy, ifc3.done, ifc3.pass, ifc3.err_cnt,
                     ifc3.first_err_valid, ifc3.first_err_vec);
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc3.start = 1'b1;
        ifc1.start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_with_start");
        n_total++;
        if (ifc1.busy !== 1'b0 || ifc1.done !== 1'b0 || ifc1.err_cnt !== 2'd0 ||
            ifc1.vec_out !== 1'b0) begin
            $display("FAIL reset_n1 busy/done/err/vec got %b/%b/%0d/%0d want 0/0/0/0",
                     ifc1.busy, ifc1.done, ifc1.err_cnt, ifc1.vec_out);
        end else n_pass++;
        ifc3.start = 1'b0;
        ifc1.start = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("idle_no_start");
    endtask

    task automatic test_sweeps();
        run_sweep3(0, 0, 0, 1'b0, "correct");
        run_sweep3(1, 1, 5, 1'b0, "bad_vec5");
        run_sweep3(2, 4, 3, 1'b0, "tied0");
        run_sweep3(3, 8, 0, 1'b0, "inverse");
    endtask

    task automatic test_start_in_run();
        run_sweep3(0, 0, 0, 1'b1, "start_in_run");
    endtask

    task automatic test_reset_mid();
        mode3 = 2;
        @(negedge clk);
        ifc3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc3.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_mid");
        run_sweep3(0, 0, 0, 1'b0, "after_reset_mid");
    endtask

    task automatic test_n1();
        run_sweep1(0, 0, "n1_ident");
        run_sweep1(1, 2, "n1_invert");
    endtask

    initial begin
        ifc3.start = 1'b0;
        ifc1.start = 1'b0;
        rst = 1'b1;
        test_reset();
        test_sweeps();
        test_start_in_run();
        test_reset_mid();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/exhaustive_sweep_checker.md
# exhaustive_sweep_checker

Parametrised, clocked exhaustive-sweep stimulus and checker for N-input combinational blocks. On `start` it walks every input vector 0 … 2^N−1 on `vec_out` and holds each for HOLD cycles. It samples the DUT response `y_in` at the end of each hold window and compares it against a truth-table parameter. It accumulates a mismatch count and captures the first failing vector, so a single bench can check any combinational function of the comb_Y* family without hand-written delay chains.

## Interface
Parameters:
- N, 3, input vector width (1…8).
- HOLD, 10, clock cycles each vector is held; the sample is taken on the last cycle (HOLD ≥ 1).
- TRUTH, 8'hE8, expected output table (2^N bits); bit i is the expected `y_in` for `vec_out == i`.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- y_in  in  1  DUT output under test.
- vec_out  out  N  stimulus vector to the DUT.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next start or reset.
- pass  out  1  valid while done; 1 when err_cnt == 0.
- err_cnt  out  N+1  number of mismatching vectors (0 … 2^N).
- first_err_valid  out  1  at least one mismatch recorded in this sweep.
- first_err_vec  out  N  lowest vector that mismatched; valid when first_err_valid.

## Operation
- State machine: IDLE → RUN → DONE.
  - DONE → RUN on start.
  - Any state → IDLE on rst.
- IDLE: all outputs 0. start=1 → RUN, with vec_out=0, hold_cnt=0, err_cnt=0, first_err_valid=0.
- RUN:
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD−1, y_in is compared with TRUTH[vec_out].
  - On mismatch, err_cnt increments. If first_err_valid=0, first_err_vec is set to vec_out and first_err_valid is set to 1.
  - Same edge: if vec_out == 2^N−1, go to DONE. Otherwise vec_out increments and hold_cnt clears.
- DONE:
  - busy=0, done=1, pass = (err_cnt == 0).
  - vec_out holds 2^N−1.
  - err_cnt and first_err_* hold their values.
  - start=1 clears the results and restarts exactly as from IDLE.
- start in RUN is ignored; the sweep continues unaffected.
- vec_out never wraps during a sweep; the terminal vector is detected by compare, not by overflow.
- err_cnt is N+1 bits, so the all-mismatch case reports 2^N without saturation or wrap.
- Reset mid-sweep: the next cycle is IDLE with all outputs 0. No partial results are retained.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0.
- All outputs are registered; there is no combinational path from y_in or start to any output.
- Let edge E0 be the edge that samples start=1. From E0, busy=1 and vec_out=0.
- Vector k is driven from edge E0+k·HOLD.
- y_in for vector k is sampled on edge E0+(k+1)·HOLD. The DUT has HOLD−1 full cycles plus the sampling cycle to settle.
- err_cnt and first_err_* update on the sampling edge.
- Final sample on edge E0+2^N·HOLD; from that same edge busy=0 and done=1. Total sweep length is 2^N·HOLD cycles.
- HOLD=1: one vector per cycle; y_in is sampled on the edge that advances vec_out.
- start and rst asserted on the same edge: rst wins.

## Test plan
- N=3, HOLD=2, TRUTH=8'hE8, y_in driven by a correct majority model → done at E0+16; err_cnt=0, pass=1, first_err_valid=0; vec_out sequence 0…7, each held 2 cycles.
- Same setup, model inverted only for vector 5 → err_cnt=1, first_err_vec=5, first_err_valid=1, pass=0.
- Same setup, y_in tied 0 → err_cnt=4, first_err_vec=3, pass=0. With y_in tied to the inverse of TRUTH → err_cnt=8 (full N+1-bit value, no wrap).
- rst asserted at E0+7 → next cycle IDLE with all outputs 0. A new start gives a clean sweep with err_cnt=0 (correct model).
- start pulsed again at E0+5 → ignored, done still at E0+16. start in DONE → results cleared and a second sweep completes correctly.
- N=1, HOLD=1, TRUTH=2'b10, y_in=vec_out → done at E0+2, pass=1. Same with y_in=~vec_out → err_cnt=2, first_err_vec=0.
